// File: rtl/random_modulo_key_ctrl_pkg.sv
// Shared types and constants for the random-modulo L1 key controller.
// The key-change FSM states, LFSR polynomial/seed and epoch width live here.
package random_modulo_key_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_SWAP  = 2'd3
    } rekey_state_e;

    localparam int EPOCH_W = 8;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: taps on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;

endpackage

// File: rtl/random_modulo_key_ctrl_if.sv
// Handshake bundle between the key controller (master) and the cache /
// software side (slave).
interface random_modulo_key_ctrl_if #(
    parameter int CNT    = 3,
    parameter int LFSR_W = 16
);
    import random_modulo_key_ctrl_pkg::*;

    logic               rekey_req_i;
    logic               seed_load_i;
    logic [LFSR_W-1:0]  seed_i;
    logic               cache_busy_i;
    logic               flush_ack_i;

    logic               flush_req_o;
    logic               stall_o;
    logic [CNT-1:0]     control_o;
    logic [EPOCH_W-1:0] epoch_o;
    logic               rekey_busy_o;

    modport master (
        input  rekey_req_i, seed_load_i, seed_i, cache_busy_i, flush_ack_i,
        output flush_req_o, stall_o, control_o, epoch_o, rekey_busy_o
    );

    modport slave (
        output rekey_req_i, seed_load_i, seed_i, cache_busy_i, flush_ack_i,
        input  flush_req_o, stall_o, control_o, epoch_o, rekey_busy_o
    );

endinterface

// File: rtl/random_modulo_lfsr.sv
// Free-running Fibonacci LFSR used as the permutation-key source; advances
// every cycle, loads a software seed, and never holds the all-zero state.
module random_modulo_lfsr
    import random_modulo_key_ctrl_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter int                KEY_W  = 3,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(LFSR_TAP_MASK),
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(LFSR_SEED)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic [KEY_W-1:0]  key
);

    logic [LFSR_W-1:0] lfsr_q;
    logic              feedback;

    assign feedback = ^(lfsr_q & TAPS);
    assign key      = lfsr_q[KEY_W-1:0];

    // NOTE: clocked state is written with <= so every register samples the
    // pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else if (seed_load) begin
            lfsr_q <= (seed == '0) ? LFSR_W'(1) : seed;
        end else begin
            lfsr_q <= {feedback, lfsr_q[LFSR_W-1:1]};
        end
    end

endmodule

// File: rtl/random_modulo_key_ctrl.sv
// Rekey controller for a randomized-modulo L1 index: drains, flushes, then
// swaps in a new Benes control word. Optional periodic rekey under
// RANDOM_MODULO_PERIODIC_REKEY_EN.
module random_modulo_key_ctrl
    import random_modulo_key_ctrl_pkg::*;
#(
    parameter int CNT            = 3,
    parameter int LFSR_W         = 16,
    parameter int REKEY_INTERVAL = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    random_modulo_key_ctrl_if.master bus
);

    if (REKEY_INTERVAL < 2) begin : g_bad_interval
        $error("REKEY_INTERVAL must be at least 2");
    end

    rekey_state_e       state_q, state_d;
    logic               pending_q;
    logic [CNT-1:0]     control_q;
    logic [EPOCH_W-1:0] epoch_q;
    logic [CNT-1:0]     lfsr_key;
    logic [CNT-1:0]     next_key;
    logic               periodic_trig;
    logic               trigger;
    logic               flush_req;
    logic               stall;

    random_modulo_lfsr #(
        .LFSR_W (LFSR_W),
        .KEY_W  (CNT)
    ) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .seed_load (bus.seed_load_i),
        .seed      (bus.seed_i),
        .key       (lfsr_key)
    );

`ifdef RANDOM_MODULO_PERIODIC_REKEY_EN
    localparam int IDLE_CNT_W = $clog2(REKEY_INTERVAL);

    logic [IDLE_CNT_W-1:0] idle_cnt_q;

    // Counts IDLE cycles only; holds while a rekey is in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt_q <= '0;
        end else if (state_q == ST_SWAP) begin
            idle_cnt_q <= '0;
        end else if (state_q == ST_IDLE && !periodic_trig) begin
            idle_cnt_q <= idle_cnt_q + IDLE_CNT_W'(1);
        end
    end

    assign periodic_trig = (state_q == ST_IDLE) &&
                           (idle_cnt_q == IDLE_CNT_W'(REKEY_INTERVAL - 1));
`else
    assign periodic_trig = 1'b0;
`endif

    assign trigger  = bus.rekey_req_i | pending_q | periodic_trig;
    assign next_key = (lfsr_key == control_q) ? (lfsr_key ^ CNT'(1)) : lfsr_key;

    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        flush_req = 1'b0;
        stall     = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                stall = 1'b0;
                if (trigger) state_d = bus.cache_busy_i ? ST_DRAIN : ST_FLUSH;
            end
            ST_DRAIN: begin
                if (!bus.cache_busy_i) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush_req = 1'b1;
                if (bus.flush_ack_i) state_d = ST_SWAP;
            end
            ST_SWAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            control_q <= '0;
            epoch_q   <= '0;
        end else begin
            state_q <= state_d;
            // In IDLE the flag is either consumed by the departing rekey or already clear.
            if (state_q == ST_IDLE) begin
                pending_q <= 1'b0;
            end else if (bus.rekey_req_i) begin
                pending_q <= 1'b1;
            end
            if (state_q == ST_SWAP) begin
                control_q <= next_key;
                epoch_q   <= epoch_q + EPOCH_W'(1);
            end
        end
    end

    assign bus.flush_req_o  = flush_req;
    assign bus.stall_o      = stall;
    assign bus.rekey_busy_o = stall;
    assign bus.control_o    = control_q;
    assign bus.epoch_o      = epoch_q;

endmodule

// File: tb/tb_random_modulo_key_ctrl.sv
// Directed-plus-random bench for random_modulo_key_ctrl (default build,
// periodic rekey disabled) with a behavioural LFSR/key reference model.
module tb_random_modulo_key_ctrl;

    localparam int CNT    = 3;
    localparam int LFSR_W = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0]    m_lfsr = 16'hACE1;
    logic [CNT-1:0] exp_control = '0;
    logic [7:0]     exp_epoch = 8'd0;

    random_modulo_key_ctrl_if #(.CNT(CNT), .LFSR_W(LFSR_W)) bus ();

    random_modulo_key_ctrl #(
        .CNT    (CNT),
        .LFSR_W (LFSR_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Polynomial x^16+x^14+x^13+x^11+1: new MSB is the xor of bits 0,2,3,5.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        int v;
        int fb;
        v  = int'(s);
        fb = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
        return 16'((v >> 1) | (fb << 15));
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset)                m_lfsr <= 16'hACE1;
        else if (bus.seed_load_i)  m_lfsr <= (bus.seed_i == 16'd0) ? 16'd1 : bus.seed_i;
        else                       m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check(32'(bus.stall_o),      0, {tag, "_stall"});
        check(32'(bus.flush_req_o),  0, {tag, "_flush_req"});
        check(32'(bus.rekey_busy_o), 0, {tag, "_busy"});
        check(32'(bus.control_o),    32'(exp_control), {tag, "_control"});
        check(32'(bus.epoch_o),      32'(exp_epoch),   {tag, "_epoch"});
    endtask

    // One complete rekey starting mid-cycle in IDLE. busy_n = cycles cache_busy_i
    // is held high from the request cycle; ack_dly = FLUSH cycles before the ack.
    task automatic rekey(input int busy_n, input int ack_dly, input int flush_pulses,
                         input bit self_trig);
        logic [CNT-1:0] k;
        if (!self_trig) bus.rekey_req_i = 1'b1;
        bus.cache_busy_i = (busy_n > 0);
        check(32'(bus.stall_o), 0, "req_cycle_stall");
        step();
        bus.rekey_req_i = 1'b0;
        if (busy_n > 0) begin
            for (int i = 1; i < busy_n; i++) begin
                bus.flush_ack_i = 1'($urandom_range(0, 1));
                check(32'(bus.stall_o),     1, "drain_stall");
                check(32'(bus.flush_req_o), 0, "drain_flush_req");
                step();
            end
            bus.cache_busy_i = 1'b0;
            bus.flush_ack_i  = 1'b0;
            check(32'(bus.stall_o),     1, "drain_last_stall");
            check(32'(bus.flush_req_o), 0, "drain_last_flush_req");
            step();
        end
        for (int i = 0; i < ack_dly; i++) begin
            bus.rekey_req_i = (i % 2 == 0) && (i / 2 < flush_pulses);
            check(32'(bus.flush_req_o), 1, "flush_req_wait");
            check(32'(bus.stall_o),     1, "flush_stall");
            step();
        end
        bus.rekey_req_i = 1'b0;
        bus.flush_ack_i = 1'b1;
        check(32'(bus.flush_req_o), 1, "flush_req_ack_cycle");
        step();
        bus.flush_ack_i = 1'b0;
        check(32'(bus.flush_req_o),  0, "swap_flush_req");
        check(32'(bus.stall_o),      1, "swap_stall");
        check(32'(bus.rekey_busy_o), 1, "swap_busy");
        check(32'(bus.control_o),    32'(exp_control), "swap_old_control");
        k = m_lfsr[CNT-1:0];
        if (k == exp_control) k = k ^ CNT'(1);
        exp_control = k;
        exp_epoch   = exp_epoch + 8'd1;
        step();
        check(32'(bus.control_o), 32'(exp_control), "new_control");
        check(32'(bus.epoch_o),   32'(exp_epoch),   "new_epoch");
        check(32'(bus.stall_o),   0,                "post_swap_stall");
    endtask

    initial begin
        bus.rekey_req_i  = 1'b0;
        bus.seed_load_i  = 1'b0;
        bus.seed_i       = '0;
        bus.cache_busy_i = 1'b0;
        bus.flush_ack_i  = 1'b0;

        // Reset held: outputs at reset values, then idle with no stimulus.
        @(negedge clk);
        check_idle("in_reset");
        step();
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check_idle("quiet");
            step();
        end

        // Minimum-latency rekey: stall for three cycles, new key after SWAP.
        rekey(0, 1, 0, 1'b0);
        check_idle("after_first");

        // Cache busy for 5 cycles: DRAIN holds off the flush.
        rekey(5, 1, 0, 1'b0);
        check_idle("after_drain");

        // Flush ack outside FLUSH is ignored.
        bus.flush_ack_i = 1'b1;
        check(32'(bus.flush_req_o), 0, "idle_ack_flush_req");
        step();
        bus.flush_ack_i = 1'b0;
        check_idle("idle_ack");
        step();

        // Three requests during FLUSH coalesce into one follow-up rekey.
        rekey(0, 6, 3, 1'b0);
        rekey(0, 1, 0, 1'b1);
        step();
        check_idle("after_coalesce");

        // Random seed load followed by randomized rekeys.
        bus.seed_i      = 16'($urandom_range(1, 65535));
        bus.seed_load_i = 1'b1;
        step();
        bus.seed_load_i = 1'b0;
        check(32'(dut.u_lfsr.lfsr_q), 32'(m_lfsr), "seed_load");
        for (int i = 0; i < 4; i++) begin
            rekey(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 0, 1'b0);
        end

        // Reset in the middle of FLUSH abandons the rekey.
        bus.rekey_req_i = 1'b1;
        step();
        bus.rekey_req_i = 1'b0;
        check(32'(bus.flush_req_o), 1, "pre_reset_flush_req");
        #2 reset = 1'b0;
        exp_control = '0;
        exp_epoch   = 8'd0;
        #1 check_idle("async_reset");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_idle("post_reset");
            step();
        end
        check(32'(dut.u_lfsr.lfsr_q), 32'(m_lfsr), "lfsr_after_reset");

        // Zero seed is replaced by 1; then 256 rekeys wrap the epoch.
        bus.seed_i      = 16'd0;
        bus.seed_load_i = 1'b1;
        step();
        bus.seed_load_i = 1'b0;
        check(32'(dut.u_lfsr.lfsr_q), 32'h1, "zero_seed_guard");
        for (int i = 0; i < 256; i++) begin
            rekey(int'($urandom_range(0, 2)), int'($urandom_range(1, 3)), 0, 1'b0);
            check(32'(dut.u_lfsr.lfsr_q != '0), 1, "lfsr_nonzero");
            check(32'(dut.u_lfsr.lfsr_q), 32'(m_lfsr), "lfsr_track");
        end
        check(32'(bus.epoch_o), 0, "epoch_wrap");
        check_idle("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/random_modulo_key_ctrl.md
RANDOM_MODULO_KEY_CTRL -- requirements
Module: random_modulo_key_ctrl

Interface
REQ-001 Parameter CNT, default 3: width of the Benes network control word driven to the L1 index permutation network.
REQ-002 Parameter LFSR_W, default 16: width of the key-generation LFSR.
REQ-003 Parameter REKEY_INTERVAL, default 1024: cycles between automatic rekeys (used only with REQ-031).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rekey_req_i  input  1  single-cycle request for a new permutation key.
REQ-007 seed_load_i  input  1  load seed_i into the LFSR this cycle.
REQ-008 seed_i  input  LFSR_W  software-supplied LFSR seed.
REQ-009 cache_busy_i  input  1  the cache has outstanding misses or fills.
REQ-010 flush_ack_i  input  1  single-cycle pulse: cache flush/invalidate complete.
REQ-011 flush_req_o  output  1  level request to flush and invalidate the L1.
REQ-012 stall_o  output  1  blocks new cache lookups while the key is changing.
REQ-013 control_o  output  CNT  registered Benes control word.
REQ-014 epoch_o  output  8  count of completed rekeys.
REQ-015 rekey_busy_o  output  1  the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, DRAIN, FLUSH and SWAP.
REQ-017 IDLE: on a rekey trigger, go to DRAIN if cache_busy_i=1, else to FLUSH.
REQ-018 DRAIN: stall_o=1; go to FLUSH in the first cycle cache_busy_i=0.
REQ-019 FLUSH: flush_req_o=1 and stall_o=1; on flush_ack_i=1 go to SWAP.
REQ-020 SWAP (exactly one cycle): control_o<=next_key, epoch_o<=epoch_o+1 (wraps 255->0), stall_o=1; then go to IDLE.
REQ-021 flush_req_o is asserted only in FLUSH and deasserts in the cycle after flush_ack_i is sampled.
REQ-022 flush_ack_i outside FLUSH SHALL be ignored.
REQ-023 The LFSR SHALL be Fibonacci with polynomial x^16+x^14+x^13+x^11+1 (LFSR_W=16) and SHALL advance every cycle.
REQ-024 seed_load_i=1: the LFSR loads seed_i, or 1 if seed_i=0; it never holds all-zero.
REQ-025 next_key = LFSR[CNT-1:0], with bit 0 inverted if that equals the current control_o, so every SWAP changes the key.
REQ-026 A rekey_req_i seen outside IDLE sets a single pending flag; multiple requests coalesce into one; the flag is a trigger in IDLE and clears on leaving IDLE.
REQ-027 Minimum latency from rekey_req_i in IDLE (cache idle, ack one cycle after flush_req_o rises) to the new control_o: 3 cycles.
REQ-028 rekey_busy_o = (state != IDLE); stall_o = state in {DRAIN, FLUSH, SWAP}.

Reset
REQ-029 While reset=0: state=IDLE, control_o=0 (identity permutation), epoch_o=0, flush_req_o=0, stall_o=0, pending=0, LFSR=16'hACE1; the block resumes normally on the first edge after reset=1.
REQ-030 Reset during DRAIN, FLUSH or SWAP SHALL abandon the rekey immediately, with no epoch increment.

Configuration
REQ-031 With RANDOM_MODULO_PERIODIC_REKEY_EN defined: an internal counter counts IDLE cycles, raises a trigger at REKEY_INTERVAL-1, and clears on every SWAP and on reset.
REQ-032 Without RANDOM_MODULO_PERIODIC_REKEY_EN: no counter exists and rekeys occur only via rekey_req_i.

Structure
REQ-033 The FSM state enum, the LFSR polynomial/seed constants and the epoch width SHALL be in defines.
REQ-034 One sub-module, random_modulo_lfsr (parameter LFSR_W, with seed-load and zero-guard), SHALL be instantiated.

Verification
REQ-035 Reset release, no stimulus -> control_o=0, epoch_o=0, flush_req_o=0, stall_o=0 indefinitely (macro off).
REQ-036 rekey_req_i at cycle 10 with cache idle, flush_ack_i one cycle after flush_req_o rises -> control_o changes at cycle 13, epoch_o=1, stall_o high for cycles 11-13.
REQ-037 cache_busy_i held high 5 cycles after rekey_req_i -> flush_req_o rises only after cache_busy_i falls; stall_o is high throughout.
REQ-038 Three rekey_req_i pulses during FLUSH -> exactly two rekeys total, epoch_o=2.
REQ-039 seed_load_i with seed_i=0, then 256 rekeys -> LFSR never all-zero, control_o differs after every SWAP, epoch_o wraps to 0.
REQ-040 Macro on, REKEY_INTERVAL=8, reset=0 asserted during FLUSH of the first automatic rekey -> all outputs at reset values; the next automatic rekey starts 8 IDLE cycles after reset release.
